// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared codes for the stall controller: hazard stop-distance codes, NOP encoding,
// FSM state encodings and the stop-code decoder.
package pipe_stall_ctrl_pkg;

  localparam logic [3:0]  PIP_0STOP  = 4'd0;
  localparam logic [3:0]  PIP_1STOP  = 4'd1;
  localparam logic [3:0]  PIP_2STOP  = 4'd2;
  localparam logic [3:0]  PIP_3STOP  = 4'd3;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_STALL   = 1'b1;

  // Codes outside the defined stop distances mean "no stall".
  function automatic logic [1:0] stop_dist(input logic [3:0] code);
    case (code)
      PIP_1STOP: return 2'd1;
      PIP_2STOP: return 2'd2;
      PIP_3STOP: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stall_perf_cnt.sv
// Free-running PERF_W-bit event counter; wraps silently to zero on overflow.
module stall_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  // Next count: advance by one on each event cycle.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for PC, IF/ID and ID/EX. Optional performance counters
// are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
`ifdef STALL_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        stop_info,
  input  logic              redirect,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              stall_busy
`ifdef STALL_PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_stall_cycles
  , output logic [PERF_W-1:0] perf_flushes
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_s;
  logic             stall_s;

  // Next-state logic and strobes; redirect overrides any stall.
  always_comb begin
    n_s        = CNT_W'(stop_dist(stop_info));
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_s    = 1'b0;
    ifid_flush = 1'b0;
    if (redirect) begin
      ifid_flush = 1'b1;
      state_d    = ST_IDLE;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (n_s != '0) begin
            stall_s = 1'b1;
            cnt_d   = n_s - CNT_ONE;
            state_d = (n_s > CNT_ONE) ? ST_STALL : ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_STALL: begin
          // Count latched at onset governs; stop_info is ignored here.
          stall_s = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STALL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output strobes; held at idle values while reset is asserted.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_flush = 1'b0;
    stall_busy = 1'b0;
    if (!rst) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      idex_flush = 1'b0;
      stall_busy = 1'b0;
    end else begin
      pc_we      = ~stall_s;
      ifid_we    = ~stall_s;
      idex_flush = stall_s | ifid_flush;
      stall_busy = stall_s;
    end
  end

  // FSM state and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  stall_perf_cnt #(.PERF_W(PERF_W)) u_perf_stall (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (stall_busy),
    .count_o (perf_stall_cycles)
  );

  stall_perf_cnt #(.PERF_W(PERF_W)) u_perf_flush (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (redirect),
    .count_o (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; output vector order is
// {pc_we, ifid_we, ifid_flush, idex_flush, stall_busy}.
module tb_pipe_stall_ctrl;

  localparam logic [4:0] O_IDLE  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_REDIR = 5'b11110;

  logic       clk;
  logic       rst;
  logic [3:0] stop_info;
  logic       redirect;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, stall_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
  logic        w_inc;
  logic [3:0]  w_cnt;
  int          exp_stalls;
  int          exp_flushes;
`endif

  int checks;
  int errors;

  pipe_stall_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stop_info  (stop_info),
    .redirect   (redirect),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .stall_busy (stall_busy)
`ifdef STALL_PERF_CNT_EN
    , .perf_stall_cycles (perf_stall_cycles)
    , .perf_flushes      (perf_flushes)
`endif
  );

`ifdef STALL_PERF_CNT_EN
  stall_perf_cnt #(.PERF_W(4)) u_wrap (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (w_inc),
    .count_o (w_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge and check the combinational outputs.
  task automatic step(input string tag, input logic r, input logic [3:0] s,
                      input logic rd, input logic [4:0] exp);
    @(negedge clk);
    rst       = r;
    stop_info = s;
    redirect  = rd;
    #1;
    chk(tag, {27'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall_busy}, {27'd0, exp});
`ifdef STALL_PERF_CNT_EN
    if (!r) begin
      exp_stalls  = 0;
      exp_flushes = 0;
    end else begin
      exp_stalls  = exp_stalls + int'(exp[0]);
      exp_flushes = exp_flushes + int'(rd);
    end
`endif
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    stop_info = 4'd3;
    redirect  = 1'b0;
`ifdef STALL_PERF_CNT_EN
    exp_stalls  = 0;
    exp_flushes = 0;
    w_inc       = 1'b0;
`endif

    // Reset held with a hazard present: no stall visible.
    step("rst_c0", 1'b0, 4'd3, 1'b0, O_IDLE);
    step("rst_c1", 1'b0, 4'd3, 1'b0, O_IDLE);
    step("rst_c2", 1'b0, 4'd3, 1'b0, O_IDLE);
    // Release: 3-cycle stall starting in the first cycle.
    step("s3_c0", 1'b1, 4'd3, 1'b0, O_STALL);
    step("s3_c1", 1'b1, 4'd0, 1'b0, O_STALL);
    step("s3_c2", 1'b1, 4'd0, 1'b0, O_STALL);
    step("s3_end", 1'b1, 4'd0, 1'b0, O_IDLE);

    // Pulse widths 1 and 2; out-of-range codes do not stall.
    step("s1_c0", 1'b1, 4'd1, 1'b0, O_STALL);
    step("s1_end", 1'b1, 4'd0, 1'b0, O_IDLE);
    step("s2_c0", 1'b1, 4'd2, 1'b0, O_STALL);
    step("s2_c1", 1'b1, 4'd0, 1'b0, O_STALL);
    step("s2_end", 1'b1, 4'd0, 1'b0, O_IDLE);
    step("s9", 1'b1, 4'd9, 1'b0, O_IDLE);
    step("s15", 1'b1, 4'd15, 1'b0, O_IDLE);

    // Redirect in the 2nd stall cycle, then a fresh stall from the held code.
    step("rd_c0", 1'b1, 4'd3, 1'b0, O_STALL);
    step("rd_c1", 1'b1, 4'd3, 1'b1, O_REDIR);
    step("rd_re0", 1'b1, 4'd3, 1'b0, O_STALL);
    step("rd_re1", 1'b1, 4'd0, 1'b0, O_STALL);
    step("rd_re2", 1'b1, 4'd0, 1'b0, O_STALL);
    step("rd_end", 1'b1, 4'd0, 1'b0, O_IDLE);

    // Held code 2 gives back-to-back stalls, busy for 4 continuous cycles.
    step("b2b_c0", 1'b1, 4'd2, 1'b0, O_STALL);
    step("b2b_c1", 1'b1, 4'd2, 1'b0, O_STALL);
    step("b2b_c2", 1'b1, 4'd2, 1'b0, O_STALL);
    step("b2b_c3", 1'b1, 4'd2, 1'b0, O_STALL);
    step("b2b_end", 1'b1, 4'd0, 1'b0, O_IDLE);

    // Redirect in IDLE beats a new hazard; nothing left over afterwards.
    step("rdi_0", 1'b1, 4'd0, 1'b1, O_REDIR);
    step("rdi_h", 1'b1, 4'd2, 1'b1, O_REDIR);
    step("rdi_end", 1'b1, 4'd0, 1'b0, O_IDLE);

    // Reset mid-stall: immediate idle outputs, no residual stall.
    step("rms_c0", 1'b1, 4'd3, 1'b0, O_STALL);
    step("rms_rst", 1'b0, 4'd0, 1'b0, O_IDLE);
    step("rms_rel", 1'b1, 4'd0, 1'b0, O_IDLE);
    step("rms_idle", 1'b1, 4'd0, 1'b0, O_IDLE);

    // One 3-cycle stall plus two redirects since the last reset.
    step("pf_s0", 1'b1, 4'd3, 1'b0, O_STALL);
    step("pf_s1", 1'b1, 4'd0, 1'b0, O_STALL);
    step("pf_s2", 1'b1, 4'd0, 1'b0, O_STALL);
    step("pf_r0", 1'b1, 4'd0, 1'b1, O_REDIR);
    step("pf_r1", 1'b1, 4'd0, 1'b1, O_REDIR);
    step("pf_end", 1'b1, 4'd0, 1'b0, O_IDLE);

`ifdef STALL_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, 32'd3);
    chk("perf_flush", perf_flushes, 32'd2);
    chk("perf_stall_model", perf_stall_cycles, 32'(exp_stalls));
    chk("perf_flush_model", perf_flushes, 32'(exp_flushes));
    // A narrow counter wraps after 2^4 events: 17 events leave 1.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      w_inc = 1'b1;
    end
    @(negedge clk);
    w_inc = 1'b0;
    #1;
    chk("perf_wrap", {28'd0, w_cnt}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Sits directly downstream of the data-hazard detector in the 5-stage RV32 core.
- Takes the detector's stop-distance code and the EX-stage redirect, and drives the per-stage write-enable and flush strobes for PC, IF/ID and ID/EX.
- A counter FSM holds PC and IF/ID for exactly the required number of cycles and injects bubbles into ID/EX.
- Redirect flushes have priority over stalls.

Parameters:
- CNT_W, 2, width of the stall-cycle counter; must hold a maximum stall of 3.
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets all state immediately.
- stop_info  input  4  stall-distance code from the hazard detector: PIP_0STOP=0, PIP_1STOP=1, PIP_2STOP=2, PIP_3STOP=3. Values 4..15 are treated as 0.
- redirect  input  1  EX stage resolved a taken branch or jump this cycle.
- pc_we  output  1  PC register write enable.
- ifid_we  output  1  IF/ID register write enable.
- ifid_flush  output  1  clear IF/ID to a NOP (0x00000013) at the next edge.
- idex_flush  output  1  load a bubble into ID/EX at the next edge.
- stall_busy  output  1  high in every stall cycle.

Behaviour:
- Reset (rst=0): state=IDLE, cnt=0. Outputs are combinational from state and inputs, so with stop_info=0 and redirect=0 they are: pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0, stall_busy=0.
- Let N = stop_info if stop_info is 1..3, else 0.
- States: IDLE, STALL.
- Stall condition: stall = (IDLE and N!=0) or STALL.
  - The stall asserts combinationally in the same cycle the hazard appears, before the rising edge.
  - While stalled: pc_we=0, ifid_we=0, idex_flush=1, stall_busy=1.
- Stall length: total stall cycles equal N exactly.
- IDLE with N!=0 and no redirect: cnt<=N-1. Next state is STALL if N>1, else IDLE.
- STALL with no redirect:
  - cnt<=cnt-1; when cnt==1, next state is IDLE.
  - stop_info is ignored while in STALL. The count latched at onset governs; no re-trigger or extension.
- Back-to-back hazards: when returning to IDLE, if stop_info is still nonzero, a new stall starts in that IDLE cycle as a fresh hazard.
- Redirect (any state) takes priority:
  - ifid_flush=1, idex_flush=1, pc_we=1, ifid_we=1, stall_busy=0.
  - Next state IDLE, cnt<=0. An in-progress stall is abandoned, because the stalled instruction is wrong-path.
- Output exclusivity: ifid_flush is asserted only on redirect. pc_we and ifid_we are always equal.
- Reset mid-stall: returns immediately to IDLE outputs; no residual stall cycles.
- Counter arithmetic: cnt is an unsigned CNT_W-bit value. It is never decremented below 1 in STALL, so it never wraps.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined, add two outputs:
  - perf_stall_cycles (PERF_W): increments in every cycle with stall_busy=1.
  - perf_flushes (PERF_W): increments in every cycle with redirect=1.
  - Both reset to 0 and wrap silently at 2^PERF_W-1 -> 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - PIP_0STOP..PIP_3STOP codes (4-bit, values 0..3).
  - NOP encoding 32'h00000013.
  - FSM state encodings IDLE=1'b0, STALL=1'b1.
- One sub-module, stall_perf_cnt: a generic saturate-free PERF_W-bit event counter, instantiated twice under STALL_PERF_CNT_EN.

Test Plan:
- Reset: hold rst=0 for 3 cycles with stop_info=3 -> pc_we=1, ifid_we=1, no flushes. After release, stall starts in the first cycle.
- stop_info=3 for one cycle, then 0 -> pc_we=0, idex_flush=1 for exactly 3 consecutive cycles, then pc_we=1.
- stop_info=1, 2 and 3 in separate runs -> stall_busy pulse widths of 1, 2 and 3 cycles. stop_info=9 -> no stall.
- stop_info=3 held, redirect=1 in the 2nd stall cycle -> that cycle has ifid_flush=1, idex_flush=1, pc_we=1. The next cycle is IDLE and re-stalls because stop_info=3 is still present.
- stop_info=2 held for 4 cycles -> two back-to-back 2-cycle stalls, stall_busy high 4 cycles continuously.
- With STALL_PERF_CNT_EN: a 3-cycle stall plus 2 redirects -> perf_stall_cycles=3, perf_flushes=2. Preload near 2^32-1 -> wraps to 0.
